div3_frame_tx: RTL and testbench
================================

// Module: div3_frame_tx
// PURPOSE
//   Serial transmitter producing MSB-first bit frames that the serial divide-by-3 checker consumes.
//   Accepts a W-bit parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
//   Appends 2 check bits so the whole (W+2)-bit frame, read as a binary number, is divisible by 3.
//   At frame end a downstream div-by-3 checker reports "divisible" (remainder 0).
// PARAMETERS
//   W  8  payload width in bits (W >= 2)
// PORTS
//   clk       in   1  clock, all state changes on rising edge
//   reset     in   1  synchronous, active-low reset
//   in_valid  in   1  in_data holds a word to send
//   in_ready  out  1  block can accept a word this cycle
//   in_data   in   W  payload, transmitted MSB first
//   tx_bit    out  1  serial data bit
//   tx_valid  out  1  tx_bit is part of a frame this cycle
//   tx_first  out  1  tx_bit is frame bit 0 (payload MSB)
//   tx_last   out  1  tx_bit is the final check bit
//   rem_out   out  2  running remainder (mod 3) of frame bits sent, including current tx_bit
// BEHAVIOUR
//   Reset (reset==0 at a rising edge):
//     - state=IDLE; tx_bit, tx_valid, tx_first, tx_last = 0; rem_out = 0.
//     - in_ready = 0 while reset is low.
//     - A reset mid-frame aborts the frame: no further bits are sent and the partial frame is discarded.
//   States:
//     - IDLE: tx_valid = 0.
//     - DATA: W cycles, payload bits.
//     - CHK: 2 cycles, check bits.
//   Handshake:
//     - in_ready = 1 in IDLE, and in the CHK cycle where tx_last = 1 (gapless back-to-back frames).
//     - A word is accepted at a rising edge where in_valid & in_ready.
//     - in_data is captured into the shift register.
//   Latency: a word accepted at edge k puts its MSB on tx_bit with tx_valid = tx_first = 1 in the cycle after edge k.
//   Frame timing: W DATA cycles, then 2 CHK cycles (c[1], then c[0]).
//     - tx_last = 1 in the c[0] cycle.
//     - Next state is DATA if a word is accepted at that edge, else IDLE.
//   Remainder: rem_next = (2*rem_prev + tx_bit) mod 3, with rem_prev = 0 at frame start.
//     - Same recurrence as the checker's states A=0, B=1, C=2.
//   Check value: r = remainder after W payload bits; c = (3 - r) mod 3, range 0..2, sent as 2 bits MSB first.
//     - Guarantee: (payload*4 + c) mod 3 == 0, so rem_out == 0 in the tx_last cycle, always.
//   All outputs are registered. tx_bit = 0 whenever tx_valid = 0.
//   in_data and in_valid are ignored when in_ready = 0; the block never stalls mid-frame.
// TESTING
//   - in_data=8'h05 (r=2, c=1) -> tx_bit 0000_0101_01 over 10 cycles; tx_first on cycle 1, tx_last on cycle 10;
//     rem_out sequence 0,0,0,0,0,1,2,2,1,0.
//   - in_data=8'h07 (r=1, c=2) -> frame 0000_0111_10 (=30); rem_out=0 at tx_last.
//     in_data=8'hFF (r=0) -> frame 1111_1111_00.
//   - Back-to-back: in_valid held high with 8'h00 then 8'hFF -> 20 consecutive tx_valid cycles, no gap;
//     tx_first on cycles 1 and 11.
//   - Reset low during payload bit 4 -> next cycle tx_valid=0, in_ready=0.
//     After release, in_ready=1 and a new frame starts cleanly with rem_out starting from 0.
//   - in_valid pulsed while busy (mid-DATA) -> ignored; the frame in flight is unchanged and no extra frame is sent.
//   - Random 1000 words, tx_bit fed to a div-by-3 checker model -> remainder 0 at every tx_last;
//     payload bits match in_data.

Source files
------------

// File: rtl/div3_frame_tx.sv
// Serial MSB-first frame transmitter.
// Each W-bit word is followed by 2 check bits so that the (W+2)-bit frame is divisible by 3.
module div3_frame_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         tx_bit,
    output logic         tx_valid,
    output logic         tx_first,
    output logic         tx_last,
    output logic [1:0]   rem_out
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rem_q, rem_d;
    logic          chk_lo_q, chk_lo_d;
    logic          tx_bit_q, tx_bit_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_first_q, tx_first_d;
    logic          tx_last_q, tx_last_d;
    logic          in_ready_q, in_ready_d;

    logic          accept;
    logic          load;
    logic [1:0]    chk_val;

    // One step of the mod-3 recurrence: (2*r + b) mod 3.
    function automatic logic [1:0] rem_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            2'd0:    n = b ? 2'd1 : 2'd0;
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        chk_lo_d   = chk_lo_q;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        tx_first_d = 1'b0;
        tx_last_d  = 1'b0;
        in_ready_d = 1'b0;
        load       = 1'b0;
        accept     = in_valid && in_ready_q;

        case (rem_q)
            2'd1:    chk_val = 2'd2;
            2'd2:    chk_val = 2'd1;
            default: chk_val = 2'd0;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            DATA: begin
                tx_valid_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    // rem_q now holds the payload remainder, so the check value is fixed here.
                    state_d  = CHK;
                    cnt_d    = '0;
                    chk_lo_d = chk_val[0];
                    tx_bit_d = chk_val[1];
                    rem_d    = rem_step(rem_q, chk_val[1]);
                end else begin
                    tx_bit_d = shift_q[W-1];
                    shift_d  = {shift_q[W-2:0], 1'b0};
                    rem_d    = rem_step(rem_q, shift_q[W-1]);
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            CHK: begin
                if (cnt_q == '0) begin
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b1;
                    tx_bit_d   = chk_lo_q;
                    rem_d      = rem_step(rem_q, chk_lo_q);
                    cnt_d      = CW'(1);
                    in_ready_d = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d    = IDLE;
                    rem_d      = 2'd0;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                rem_d      = 2'd0;
                in_ready_d = 1'b1;
            end
        endcase

        if (load) begin
            state_d    = DATA;
            shift_d    = {in_data[W-2:0], 1'b0};
            cnt_d      = '0;
            rem_d      = {1'b0, in_data[W-1]};
            tx_bit_d   = in_data[W-1];
            tx_valid_d = 1'b1;
            tx_first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            rem_q      <= 2'd0;
            chk_lo_q   <= 1'b0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_first_q <= 1'b0;
            tx_last_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            chk_lo_q   <= chk_lo_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_first_q <= tx_first_d;
            tx_last_q  <= tx_last_d;
            in_ready_q <= in_ready_d;
        end
    end

    // The ready flop idles high so a word can be taken the first cycle after reset release.
    assign in_ready = in_ready_q & reset;
    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign tx_first = tx_first_q;
    assign tx_last  = tx_last_q;
    assign rem_out  = rem_q;

endmodule

// File: tb/tb_div3_frame_tx.sv
// Scoreboard bench for div3_frame_tx: the driver queues expected frame bits on acceptance,
// the monitor pops and compares them whenever tx_valid is seen.
module tb_div3_frame_tx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         tx_bit;
   logic         tx_valid;
   logic         tx_first;
   logic         tx_last;
   logic [1:0]   rem_out;

   typedef struct packed {
      logic       b;
      logic       f;
      logic       l;
      logic [1:0] r;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   run_len = 0;
   int   max_run = 0;

   div3_frame_tx #(.W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .tx_bit   (tx_bit),
      .tx_valid (tx_valid),
      .tx_first (tx_first),
      .tx_last  (tx_last),
      .rem_out  (rem_out)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   // Single comparison point shared by driver and monitor
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Queue one 10-bit frame; expected remainder is the prefix value mod 3
   task automatic pushFrame(input logic [W+1:0] frame);
      exp_t e;
      int   fv;
      fv = int'(frame);
      for (int i = 0; i < W + 2; i++) begin
         e.b = frame[W+1-i];
         e.f = (i == 0);
         e.l = (i == W + 1);
         e.r = 2'((fv >> (W + 1 - i)) % 3);
         exp_q.push_back(e);
      end
   endtask

   // Present a word and hold it until accepted; queues its frame at the accepting edge
   task automatic applyStimulus(input logic [W-1:0] word, input logic [W+1:0] frame, output int waits);
      in_valid = 1'b1;
      in_data  = word;
      waits    = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         waits++;
         if (waits > 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=%0d expected=%0d", waits, 0);
            @(posedge clk);
            #1;
            return;
         end
      end
      pushFrame(frame);
      @(posedge clk);
      #1;
   endtask

   // Wait for the scoreboard to empty, bounded
   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout actual=%0d expected=%0d", exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every valid bit against the scoreboard, and idle cycles against zero
   always @(negedge clk) begin
      exp_t e;
      if (tx_valid === 1'b1) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_bit actual=%0d expected=%0d at %0t", 1, 0, $time);
         end else begin
            e = exp_q.pop_front();
            checkOutput("tx_bit", 32'(tx_bit), 32'(e.b));
            checkOutput("tx_first", 32'(tx_first), 32'(e.f));
            checkOutput("tx_last", 32'(tx_last), 32'(e.l));
            checkOutput("rem_out", 32'(rem_out), 32'(e.r));
         end
      end else begin
         run_len = 0;
         checkOutput("idle_outputs", 32'({tx_valid, tx_bit, tx_first, tx_last}), 32'd0);
      end
   end

   initial begin
      int           w0;
      int           w1;
      logic [W-1:0] rw;
      logic [1:0]   rc;
      int           rr;

      $display("[TB] start");

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_rem_out", 32'(rem_out), 32'd0);
      checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single frames with hand-computed check bits
      applyStimulus(8'h05, 10'b0000_0101_01, w0);
      in_valid = 1'b0;
      waitDrain(50);
      applyStimulus(8'h07, 10'b0000_0111_10, w0);
      in_valid = 1'b0;
      waitDrain(50);
      applyStimulus(8'hFF, 10'b1111_1111_00, w0);
      in_valid = 1'b0;
      waitDrain(50);

      // Back-to-back frames with in_valid held high
      max_run = 0;
      applyStimulus(8'h00, 10'b0000_0000_00, w0);
      applyStimulus(8'hFF, 10'b1111_1111_00, w1);
      in_valid = 1'b0;
      checkOutput("b2b_first_wait", 32'(w0), 32'd0);
      checkOutput("b2b_second_wait", 32'(w1), 32'd9);
      waitDrain(50);
      checkOutput("b2b_run_length", 32'(max_run), 32'd20);

      // Reset during payload bit 4 aborts the frame
      applyStimulus(8'hA5, 10'b1010_0101_00, w0);
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      @(negedge clk);
      checkOutput("abort_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
      checkOutput("abort_rem_out", 32'(rem_out), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_abort", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(8'h07, 10'b0000_0111_10, w0);
      in_valid = 1'b0;
      waitDrain(50);

      // in_valid pulsed mid-frame must be ignored
      applyStimulus(8'h05, 10'b0000_0101_01, w0);
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitDrain(50);
      repeat (15) @(posedge clk);
      #1;

      // Random words, mixing back-to-back and gapped frames
      for (int k = 0; k < 1000; k++) begin
         rw = W'($urandom_range(0, 255));
         rr = int'(rw) % 3;
         rc = 2'((3 - rr) % 3);
         applyStimulus(rw, {rw, rc}, w0);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      in_valid = 1'b0;
      waitDrain(100);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
